// File: rtl/squeeze_serializer_if.sv
// Stream/bus bundle between the squeeze serializer, the permutation core
// and the downstream consumer of squeezed output words.
interface squeeze_serializer_if #(
    parameter int INWIDTH    = 8,
    parameter int BLOCKWIDTH = 256,
    parameter int LENWIDTH   = 16
);
    logic                  start;
    logic [LENWIDTH-1:0]   out_len;
    logic [BLOCKWIDTH-1:0] block_in;
    logic                  block_valid;
    logic                  block_ready;
    logic [INWIDTH-1:0]    serial_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  next_block;
    logic                  busy;
    logic                  done;

    // Controller / core / consumer side
    modport master (
        output start, out_len, block_in, block_valid, out_ready,
        input  block_ready, serial_out, out_valid, next_block, busy, done
    );

    // Serializer side
    modport slave (
        input  start, out_len, block_in, block_valid, out_ready,
        output block_ready, serial_out, out_valid, next_block, busy, done
    );
endinterface

// File: rtl/squeeze_serializer.sv
// Squeeze-side serializer: takes full squeeze blocks from the permutation
// core and emits exactly out_len INWIDTH-bit words, LSB word first, asking
// the core for a further permutation whenever a block runs out early.
module squeeze_serializer #(
    parameter int INWIDTH    = 8,
    parameter int BLOCKWIDTH = 256,
    parameter int LENWIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    squeeze_serializer_if.slave  bus
);
    localparam int WORDS = BLOCKWIDTH / INWIDTH;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        SHIFT,
        FINISH
    } state_t;

    state_t                state;
    logic [BLOCKWIDTH-1:0] shreg;
    logic [LENWIDTH-1:0]   remaining;
    logic [WCW-1:0]        word_cnt;
    logic                  block_ready;
    logic                  out_valid;
    logic                  next_block;
    logic                  busy;
    logic                  done;

    // The current word is always the low slice of the shift register, so
    // it is registered and held for free while the consumer stalls.
    assign bus.serial_out  = shreg[INWIDTH-1:0];
    assign bus.block_ready = block_ready;
    assign bus.out_valid   = out_valid;
    assign bus.next_block  = next_block;
    assign bus.busy        = busy;
    assign bus.done        = done;

    // Control FSM with registered outputs; clear discards any partial block.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            shreg       <= '0;
            remaining   <= '0;
            word_cnt    <= '0;
            block_ready <= 1'b0;
            out_valid   <= 1'b0;
            next_block  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            next_block <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy <= 1'b1;
                        if (bus.out_len != '0) begin
                            remaining   <= bus.out_len;
                            block_ready <= 1'b1;
                            state       <= WAIT_BLOCK;
                        end else begin
                            // Nothing owed: skip straight to the done pulse.
                            state <= FINISH;
                        end
                    end
                end
                WAIT_BLOCK: begin
                    if (bus.block_valid && block_ready) begin
                        shreg       <= bus.block_in;
                        word_cnt    <= '0;
                        block_ready <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_valid && bus.out_ready) begin
                        shreg    <= shreg >> INWIDTH;
                        word_cnt <= word_cnt + WCW'(1);
                        if (remaining != '0) begin
                            remaining <= remaining - LENWIDTH'(1);
                        end
                        if (remaining == LENWIDTH'(1)) begin
                            // Request satisfied; wins over end-of-block.
                            out_valid <= 1'b0;
                            state     <= FINISH;
                        end else if (word_cnt == LAST_WORD) begin
                            // Block exhausted but more owed: fetch another.
                            out_valid   <= 1'b0;
                            next_block  <= 1'b1;
                            block_ready <= 1'b1;
                            state       <= WAIT_BLOCK;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_squeeze_serializer.sv
// Scoreboard bench for squeeze_serializer: a block supplier, a consumer
// ready generator and a monitor run alongside the directed/random stimulus.
module tb_squeeze_serializer;
    localparam int INW   = 8;
    localparam int BLKW  = 256;
    localparam int LENW  = 16;
    localparam int WORDS = BLKW / INW;

    logic clk = 1'b0;
    logic clear;

    squeeze_serializer_if #(.INWIDTH(INW), .BLOCKWIDTH(BLKW), .LENWIDTH(LENW)) bus ();

    squeeze_serializer #(.INWIDTH(INW), .BLOCKWIDTH(BLKW), .LENWIDTH(LENW)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt   = 0;
    int nb_cnt     = 0;
    int words_seen = 0;
    int rdy_mode   = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0
    bit blk_gaps   = 1'b0;

    logic [INW-1:0]  exp_q[$];
    logic [BLKW-1:0] blk_q[$];
    logic [BLKW-1:0] pend_q[$];
    int              hs_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BLKW-1:0] rand_block();
        logic [BLKW-1:0] b;
        for (int i = 0; i < BLKW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [BLKW-1:0] byte_block(input int base);
        logic [BLKW-1:0] b;
        for (int i = 0; i < WORDS; i++) b[i*INW +: INW] = INW'(base + i);
        return b;
    endfunction

    // Monitor: scoreboard compare on every output handshake, pulse counting.
    logic           prev_stall = 1'b0;
    logic [INW-1:0] prev_word  = '0;
    always @(negedge clk) begin
        cyc++;
        if (clear) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                check("busy_low_with_done", 64'(bus.busy), 64'd0);
            end
            if (bus.next_block) nb_cnt++;
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_word", 64'(bus.serial_out), 64'(prev_word));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = bus.serial_out;
            if (bus.out_valid && bus.out_ready) begin
                logic [INW-1:0] e;
                hs_cyc.push_back(cyc);
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(bus.serial_out), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("word %0d: got %02h expected %02h", words_seen, bus.serial_out, e);
                    check("word", 64'(bus.serial_out), 64'(e));
                end
            end
        end
    end

    // Consumer ready generator.
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: bus.out_ready = 1'($urandom % 2);
                2: begin
                    bus.out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Upstream permutation core model: offers queued blocks, pops on accept.
    initial begin
        bit hs;
        bus.block_valid = 1'b0;
        bus.block_in    = '0;
        forever begin
            @(negedge clk);
            hs = bus.block_valid && bus.block_ready && !clear;
            @(posedge clk); #1;
            if (hs && blk_q.size() > 0) void'(blk_q.pop_front());
            if (blk_q.size() > 0 && (!blk_gaps || ($urandom % 4) != 0)) begin
                bus.block_valid = 1'b1;
                bus.block_in    = blk_q[0];
            end else begin
                bus.block_valid = 1'b0;
            end
        end
    end

    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.out_len = LENW'(len);
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        exp_q.delete();
        blk_q.delete();
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // One squeeze request; expected words come from the block list with
    // plain byte arithmetic. extra_at > 0 fires a second (ignored) start.
    task automatic squeeze(input int len, input bit chk_consec, input int extra_at);
        int nblk, d0, n0, waited;
        logic [BLKW-1:0] blks[$];
        logic [BLKW-1:0] t;
        bit got;
        nblk = (len + WORDS - 1) / WORDS;
        d0 = done_cnt;
        n0 = nb_cnt;
        for (int b = 0; b < nblk; b++) begin
            if (pend_q.size() > 0) blks.push_back(pend_q.pop_front());
            else blks.push_back(rand_block());
        end
        for (int k = 0; k < len; k++) begin
            t = blks[k / WORDS] >> (INW * (k % WORDS));
            exp_q.push_back(t[INW-1:0]);
        end
        foreach (blks[i]) blk_q.push_back(blks[i]);
        hs_cyc.delete();
        $display("squeeze len=%0d blocks=%0d", len, nblk);
        pulse_start(len);
        if (extra_at > 0) begin
            repeat (extra_at - 1) @(posedge clk);
            pulse_start(5);
        end
        got = 1'b0;
        waited = 0;
        while (!got && waited < 40 * len + 400) begin
            @(negedge clk); #1;
            waited++;
            if (done_cnt != d0) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 64'd0, 64'd1);
            do_clear();
        end else begin
            repeat (4) @(negedge clk);
            #1;
            check("done_count", 64'(done_cnt - d0), 64'd1);
            check("next_block_count", 64'(nb_cnt - n0), 64'(nblk - 1));
            check("words_left", 64'(exp_q.size()), 64'd0);
            check("blocks_left", 64'(blk_q.size()), 64'd0);
            check("busy_after", 64'(bus.busy), 64'd0);
            if (chk_consec && hs_cyc.size() > 0)
                check("consecutive_span", 64'(hs_cyc[$] - hs_cyc[0]), 64'(len - 1));
        end
    endtask

    initial begin
        int w0, waited, d0;
        clear       = 1'b1;
        bus.start   = 1'b0;
        bus.out_len = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_block_ready", 64'(bus.block_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_next_block", 64'(bus.next_block), 64'd0);
        check("rst_serial_out", 64'(bus.serial_out), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0;

        // Clear asserted mid-SHIFT after three words.
        $display("test: clear mid-shift");
        blk_q.push_back(rand_block());
        for (int k = 0; k < WORDS; k++) begin
            logic [BLKW-1:0] t;
            t = blk_q[0] >> (INW * k);
            exp_q.push_back(t[INW-1:0]);
        end
        w0 = words_seen;
        pulse_start(WORDS);
        waited = 0;
        while (words_seen < w0 + 3 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("mid_words_reached", 64'(words_seen >= w0 + 3), 64'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        #1;
        check("clr_out_valid", 64'(bus.out_valid), 64'd0);
        check("clr_busy", 64'(bus.busy), 64'd0);
        check("clr_block_ready", 64'(bus.block_ready), 64'd0);
        check("clr_next_block", 64'(bus.next_block), 64'd0);
        exp_q.delete();
        blk_q.delete();
        @(posedge clk); #1;
        clear = 1'b0;
        squeeze(2, 1'b0, 0);

        // Single block, bytes 0x00..0x1F, full rate.
        $display("test: single block");
        pend_q.push_back(byte_block(8'h00));
        squeeze(WORDS, 1'b1, 0);

        // Two blocks, 40 words.
        $display("test: multi block");
        pend_q.push_back(byte_block(8'h00));
        pend_q.push_back(byte_block(8'hA0));
        squeeze(40, 1'b0, 0);

        // Backpressure pattern 1,0,0.
        $display("test: backpressure");
        rdy_mode = 2;
        pend_q.push_back(byte_block(8'h00));
        squeeze(4, 1'b0, 0);
        rdy_mode = 0;

        // Zero length: done two cycles after start, no block consumed.
        $display("test: zero length");
        d0 = done_cnt;
        blk_q.push_back(rand_block());
        pulse_start(0);
        @(negedge clk); #1;
        check("zl_done_early", 64'(bus.done), 64'd0);
        check("zl_block_ready", 64'(bus.block_ready), 64'd0);
        @(negedge clk); #1;
        check("zl_done", 64'(bus.done), 64'd1);
        check("zl_block_ready2", 64'(bus.block_ready), 64'd0);
        check("zl_no_consume", 64'(blk_q.size()), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("zl_done_count", 64'(done_cnt - d0), 64'd1);
        blk_q.delete();
        repeat (3) @(posedge clk);

        // Second start while busy must be ignored.
        $display("test: start while busy");
        squeeze(3, 1'b0, 1);
        squeeze(3, 1'b0, 3);

        // Randomized requests with random backpressure and block gaps.
        $display("test: random");
        blk_gaps = 1'b1;
        for (int it = 0; it < 20; it++) begin
            rdy_mode = int'($urandom_range(0, 1));
            squeeze(int'($urandom_range(1, 100)), 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
